// File: rtl/pdn_power_sequencer.sv
// Supply-domain sequencer: ramps rails up in ascending order and down in descending
// order with a programmable settle gap, times out missing power-good and drops all rails on a fault.
module pdn_power_sequencer #(
    parameter int NUM_DOMAINS = 6,
    parameter int DELAY_W     = 8,
    parameter int TIMEOUT     = 255,
    parameter int TMO_W       = 8,
    localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_on,
    input  logic                   req_off,
    input  logic [NUM_DOMAINS-1:0] domain_mask,
    input  logic [DELAY_W-1:0]     delay_cfg,
    input  logic [NUM_DOMAINS-1:0] pgood,
    output logic [NUM_DOMAINS-1:0] en,
    output logic                   busy,
    output logic                   all_on,
    output logic                   fault,
    output logic [IDX_W-1:0]       fault_idx
);

    localparam int CNT_W = (TMO_W > DELAY_W + 1) ? TMO_W : DELAY_W + 1;

    // Bits [4:2] of the encoding are the fault/all_on/busy flags, so those outputs come straight off flops.
    typedef enum logic [4:0] {
        OFF       = 5'b00000,
        UP_WAIT   = 5'b00100,
        UP_SETTLE = 5'b00101,
        DN_SETTLE = 5'b00110,
        ON        = 5'b01000,
        FAULT     = 5'b10000
    } state_t;

    state_t                  state_reg;
    logic [NUM_DOMAINS-1:0]  mask_reg;
    logic [NUM_DOMAINS-1:0]  en_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [IDX_W-1:0]        fault_idx_reg;
    logic [CNT_W-1:0]        cnt_reg;

    logic [NUM_DOMAINS-1:0]  drop;
    logic [IDX_W-1:0]        first_idx;
    logic [IDX_W-1:0]        drop_idx;
    logic [IDX_W-1:0]        nxt_idx;
    logic [IDX_W-1:0]        top_en_idx;
    logic                    nxt_any;
    logic                    drop_any;
    logic                    settle_done;
    logic                    timed_out;
    logic [CNT_W-1:0]        cnt_inc;

    // A rail still inside its own power-good wait is not yet monitored.
    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_drop
            assign drop[gi] = en_reg[gi] & ~pgood[gi]
                            & ~((state_reg == UP_WAIT) && (idx_reg == IDX_W'(gi)));
        end
    endgenerate

    assign drop_any    = |drop;
    assign settle_done = (cnt_reg >= CNT_W'(delay_cfg));
    assign timed_out   = (cnt_reg >= CNT_W'(TIMEOUT - 1));
    assign cnt_inc     = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        first_idx  = '0;
        drop_idx   = '0;
        nxt_idx    = '0;
        nxt_any    = 1'b0;
        top_en_idx = '0;
        for (int j = NUM_DOMAINS - 1; j >= 0; j--) begin
            if (domain_mask[j]) first_idx = IDX_W'(j);
            if (drop[j])        drop_idx  = IDX_W'(j);
            if (mask_reg[j] && (IDX_W'(j) > idx_reg)) begin
                nxt_idx = IDX_W'(j);
                nxt_any = 1'b1;
            end
        end
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            if (en_reg[j]) top_en_idx = IDX_W'(j);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= OFF;
            mask_reg      <= '0;
            en_reg        <= '0;
            idx_reg       <= '0;
            fault_idx_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                OFF: begin
                    if (req_on && !req_off && (|domain_mask)) begin
                        mask_reg           <= domain_mask;
                        idx_reg            <= first_idx;
                        en_reg[first_idx]  <= 1'b1;
                        cnt_reg            <= '0;
                        state_reg          <= UP_WAIT;
                    end
                end
                UP_WAIT: begin
                    if (drop_any) begin
                        en_reg        <= '0;
                        fault_idx_reg <= drop_idx;
                        state_reg     <= FAULT;
                    end else if (!pgood[idx_reg] && timed_out) begin
                        en_reg        <= '0;
                        fault_idx_reg <= idx_reg;
                        state_reg     <= FAULT;
                    end else if (req_off) begin
                        en_reg[top_en_idx] <= 1'b0;
                        idx_reg            <= top_en_idx;
                        cnt_reg            <= '0;
                        state_reg          <= DN_SETTLE;
                    end else if (pgood[idx_reg]) begin
                        cnt_reg   <= '0;
                        state_reg <= UP_SETTLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                UP_SETTLE: begin
                    if (drop_any) begin
                        en_reg        <= '0;
                        fault_idx_reg <= drop_idx;
                        state_reg     <= FAULT;
                    end else if (req_off) begin
                        en_reg[top_en_idx] <= 1'b0;
                        idx_reg            <= top_en_idx;
                        cnt_reg            <= '0;
                        state_reg          <= DN_SETTLE;
                    end else if (settle_done) begin
                        if (nxt_any) begin
                            idx_reg         <= nxt_idx;
                            en_reg[nxt_idx] <= 1'b1;
                            cnt_reg         <= '0;
                            state_reg       <= UP_WAIT;
                        end else begin
                            state_reg <= ON;
                        end
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                ON: begin
                    if (drop_any) begin
                        en_reg        <= '0;
                        fault_idx_reg <= drop_idx;
                        state_reg     <= FAULT;
                    end else if (req_off) begin
                        en_reg[top_en_idx] <= 1'b0;
                        idx_reg            <= top_en_idx;
                        cnt_reg            <= '0;
                        state_reg          <= DN_SETTLE;
                    end
                end
                DN_SETTLE: begin
                    if (settle_done) begin
                        if (|en_reg) begin
                            en_reg[top_en_idx] <= 1'b0;
                            idx_reg            <= top_en_idx;
                            cnt_reg            <= '0;
                        end else begin
                            state_reg <= OFF;
                        end
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                FAULT: begin
                    if (req_off && !req_on) state_reg <= OFF;
                end
                default: begin
                    en_reg    <= '0;
                    state_reg <= OFF;
                end
            endcase
        end
    end

    assign en        = en_reg;
    assign busy      = state_reg[2];
    assign all_on    = state_reg[3];
    assign fault     = state_reg[4];
    assign fault_idx = fault_idx_reg;

endmodule
